// File: rtl/eaf_req_pkg.sv
// Shared types for the EAF cache requester: command opcodes, queued command record, FSM states.
// Also provides the line-address helper used when commands are enqueued.
package eaf_req_pkg;

    localparam int EAF_ADDR_WIDTH = 32;

    typedef enum logic {
        OP_TEST   = 1'b0,
        OP_INSERT = 1'b1
    } op_t;

    typedef struct packed {
        op_t                       op;
        logic [EAF_ADDR_WIDTH-1:0] addr;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [EAF_ADDR_WIDTH-1:0] line_addr(
        input logic [EAF_ADDR_WIDTH-1:0] addr,
        input int                        offset_bits
    );
        logic [EAF_ADDR_WIDTH-1:0] mask;
        mask = '1;
        mask = mask << offset_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/eaf_req_fifo.sv
// Command FIFO with two ordered write ports (port 0 lands first) and one read port.
// The head is always visible on rd_data_o; count_o is the registered occupancy, no bypass.
module eaf_req_fifo
    import eaf_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr0_en_i,
    input  cmd_t                   wr0_data_i,
    input  logic                   wr1_en_i,
    input  cmd_t                   wr1_data_i,
    input  logic                   rd_en_i,
    output cmd_t                   rd_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    // Port 1 lands one slot past port 0 only when port 0 also writes this cycle.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q + PW'(wr0_en_i) + PW'(wr1_en_i);
        rptr_d  = rptr_q;
        count_d = count_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_en_i);
        if (wr0_en_i) begin
            mem_d[wptr_q] = wr0_data_i;
        end
        if (wr1_en_i) begin
            mem_d[wptr_q + PW'(wr0_en_i)] = wr1_data_i;
        end
        if (rd_en_i) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign rd_data_o = mem_q[rptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/eaf_cache_requester.sv
// Cache-side initiator for the EAF bloom filter: queues misses (tests) and evictions (inserts),
// issues them one at a time and returns MRU/LRU fill positions. Optional counters: EAF_REQ_STATS_EN.
module eaf_cache_requester
    import eaf_req_pkg::*;
#(
    parameter int ADDR_WIDTH  = EAF_ADDR_WIDTH,
    parameter int OFFSET_BITS = 6,
    parameter int FIFO_DEPTH  = 4,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_valid_i,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    output logic                  miss_ready_o,
    input  logic                  evict_valid_i,
    input  logic [ADDR_WIDTH-1:0] evict_addr_i,
    output logic                  evict_ready_o,
    output logic [ADDR_WIDTH-1:0] eaf_addr_o,
    output logic                  eaf_test_o,
    output logic                  eaf_insert_o,
    input  logic                  eaf_exists_i,
    output logic                  fill_valid_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic                  fill_mru_o,
    input  logic                  fill_ready_i
`ifdef EAF_REQ_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_tests_o,
    output logic [STAT_WIDTH-1:0] stat_hits_o,
    output logic [STAT_WIDTH-1:0] stat_inserts_o,
    output logic [STAT_WIDTH-1:0] stat_full_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]         count;
    logic [CW-1:0]         free;
    logic                  miss_acc, evict_acc;
    logic                  wr0_en, wr1_en, pop;
    cmd_t                  miss_cmd, evict_cmd, wr0_cmd, head;

    state_t                state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] eaf_addr_q, eaf_addr_d;
    logic                  test_q, test_d;
    logic                  insert_q, insert_d;
    logic                  fill_valid_q, fill_valid_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic                  fill_mru_q, fill_mru_d;

    // Readiness looks only at registered occupancy; a simultaneous miss reserves the first free slot.
    assign free          = CW'(FIFO_DEPTH) - count;
    assign miss_ready_o  = (free != '0);
    assign evict_ready_o = miss_valid_i ? (free >= CW'(2)) : (free != '0);
    assign miss_acc      = miss_valid_i & miss_ready_o;
    assign evict_acc     = evict_valid_i & evict_ready_o;

    assign miss_cmd  = '{op: OP_TEST,   addr: line_addr(miss_addr_i, OFFSET_BITS)};
    assign evict_cmd = '{op: OP_INSERT, addr: line_addr(evict_addr_i, OFFSET_BITS)};
    assign wr0_en    = miss_acc | evict_acc;
    assign wr0_cmd   = miss_acc ? miss_cmd : evict_cmd;
    assign wr1_en    = miss_acc & evict_acc;

    eaf_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr0_en_i   (wr0_en),
        .wr0_data_i (wr0_cmd),
        .wr1_en_i   (wr1_en),
        .wr1_data_i (evict_cmd),
        .rd_en_i    (pop),
        .rd_data_o  (head),
        .count_o    (count)
    );

    // Pulses are registered on the IDLE->ISSUE transition so they are high for exactly the ISSUE cycle.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        eaf_addr_d   = eaf_addr_q;
        test_d       = 1'b0;
        insert_d     = 1'b0;
        fill_valid_d = fill_valid_q;
        fill_addr_d  = fill_addr_q;
        fill_mru_d   = fill_mru_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    cmd_d      = head;
                    eaf_addr_d = head.addr;
                    test_d     = (head.op == OP_TEST);
                    insert_d   = (head.op == OP_INSERT);
                    state_d    = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (cmd_q.op == OP_TEST) begin
                    fill_valid_d = 1'b1;
                    fill_addr_d  = cmd_q.addr;
                    fill_mru_d   = eaf_exists_i;
                    state_d      = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (fill_ready_i) begin
                    fill_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            eaf_addr_q   <= '0;
            test_q       <= 1'b0;
            insert_q     <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_mru_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            eaf_addr_q   <= eaf_addr_d;
            test_q       <= test_d;
            insert_q     <= insert_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_mru_q   <= fill_mru_d;
        end
    end

    assign eaf_addr_o   = eaf_addr_q;
    assign eaf_test_o   = test_q;
    assign eaf_insert_o = insert_q;
    assign fill_valid_o = fill_valid_q;
    assign fill_addr_o  = fill_addr_q;
    assign fill_mru_o   = fill_mru_q;

`ifdef EAF_REQ_STATS_EN
    logic [STAT_WIDTH-1:0] tests_q, tests_d;
    logic [STAT_WIDTH-1:0] hits_q, hits_d;
    logic [STAT_WIDTH-1:0] inserts_q, inserts_d;
    logic [STAT_WIDTH-1:0] full_q, full_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        tests_d   = tests_q;
        hits_d    = hits_q;
        inserts_d = inserts_q;
        full_d    = full_q;
        if (state_q == ISSUE && cmd_q.op == OP_TEST && tests_q != '1) begin
            tests_d = tests_q + STAT_WIDTH'(1);
        end
        if (state_q == WAIT && cmd_q.op == OP_TEST && eaf_exists_i && hits_q != '1) begin
            hits_d = hits_q + STAT_WIDTH'(1);
        end
        if (state_q == ISSUE && cmd_q.op == OP_INSERT && inserts_q != '1) begin
            inserts_d = inserts_q + STAT_WIDTH'(1);
        end
        if (count == CW'(FIFO_DEPTH) && full_q != '1) begin
            full_d = full_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tests_q   <= '0;
            hits_q    <= '0;
            inserts_q <= '0;
            full_q    <= '0;
        end else begin
            tests_q   <= tests_d;
            hits_q    <= hits_d;
            inserts_q <= inserts_d;
            full_q    <= full_d;
        end
    end

    assign stat_tests_o   = tests_q;
    assign stat_hits_o    = hits_q;
    assign stat_inserts_o = inserts_q;
    assign stat_full_o    = full_q;
`endif

endmodule

// File: tb/tb_eaf_cache_requester.sv
// Testbench for eaf_cache_requester: address-table loop, scoreboard on the filter and fill ports,
// plus hand-written sequences for ordering, back-pressure and mid-operation reset.
module tb_eaf_cache_requester;

   localparam logic [31:0] LINE_MASK = 32'hFFFF_FFC0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        miss_valid_i = 1'b0;
   logic [31:0] miss_addr_i = '0;
   logic        miss_ready_o;
   logic        evict_valid_i = 1'b0;
   logic [31:0] evict_addr_i = '0;
   logic        evict_ready_o;
   logic [31:0] eaf_addr_o;
   logic        eaf_test_o;
   logic        eaf_insert_o;
   logic        eaf_exists_i = 1'b0;
   logic        fill_valid_o;
   logic [31:0] fill_addr_o;
   logic        fill_mru_o;
   logic        fill_ready_i = 1'b0;
`ifdef EAF_REQ_STATS_EN
   logic [15:0] stat_tests_o;
   logic [15:0] stat_hits_o;
   logic [15:0] stat_inserts_o;
   logic [15:0] stat_full_o;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        op;
      logic [31:0] addr;
   } issue_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        mru;
   } fill_t;

   issue_t issueQ[$];
   fill_t  fillQ[$];
   logic   hitQ[$];

   int   testSeq = 0;
   int   drvSeq = 0;
   logic pendHit = 1'b0;
   logic fillSeen = 1'b0;

   eaf_cache_requester dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .miss_valid_i  (miss_valid_i),
      .miss_addr_i   (miss_addr_i),
      .miss_ready_o  (miss_ready_o),
      .evict_valid_i (evict_valid_i),
      .evict_addr_i  (evict_addr_i),
      .evict_ready_o (evict_ready_o),
      .eaf_addr_o    (eaf_addr_o),
      .eaf_test_o    (eaf_test_o),
      .eaf_insert_o  (eaf_insert_o),
      .eaf_exists_i  (eaf_exists_i),
      .fill_valid_o  (fill_valid_o),
      .fill_addr_o   (fill_addr_o),
      .fill_mru_o    (fill_mru_o),
      .fill_ready_i  (fill_ready_i)
`ifdef EAF_REQ_STATS_EN
      ,
      .stat_tests_o   (stat_tests_o),
      .stat_hits_o    (stat_hits_o),
      .stat_inserts_o (stat_inserts_o),
      .stat_full_o    (stat_full_o)
`endif
   );

   always #5 clk = ~clk;

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Drives one cycle of requests; accepted ones are queued on the scoreboard, miss ahead of eviction.
   task automatic applyStimulus(input logic mv, input logic [31:0] ma, input logic mh,
                                input logic ev, input logic [31:0] ea,
                                output logic macc, output logic eacc);
      miss_valid_i  = mv;
      miss_addr_i   = ma;
      evict_valid_i = ev;
      evict_addr_i  = ea;
      #1;
      macc = mv & miss_ready_o;
      eacc = ev & evict_ready_o;
      if (macc) begin
         issueQ.push_back({1'b0, ma & LINE_MASK});
         fillQ.push_back({ma & LINE_MASK, mh});
         hitQ.push_back(mh);
      end
      if (eacc) begin
         issueQ.push_back({1'b1, ea & LINE_MASK});
      end
      stepCycle();
      miss_valid_i  = 1'b0;
      evict_valid_i = 1'b0;
   endtask

   task automatic waitFill(input int budget);
      int n;
      n = 0;
      while (!fill_valid_o && n < budget) begin
         stepCycle();
         n++;
      end
      if (!fill_valid_o) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_fill: got timeout expected fill_valid_o=1 at %0t", $time);
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((issueQ.size() != 0 || fillQ.size() != 0 || fill_valid_o) && n < budget) begin
         stepCycle();
         n++;
      end
      if (issueQ.size() != 0 || fillQ.size() != 0 || fill_valid_o) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d issues %0d fills pending expected 0 at %0t",
                  issueQ.size(), fillQ.size(), $time);
      end
      repeat (2) stepCycle();
   endtask

   // Scoreboard monitor, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      issue_t ei;
      fill_t  ef;
      if (!rst_n) begin
         fillSeen = 1'b0;
      end else begin
         if (eaf_test_o || eaf_insert_o) begin
            checkOutput("pulse_excl", 32'(eaf_test_o & eaf_insert_o), 32'd0);
            if (issueQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL issue_unexp: got pulse addr 0x%08h expected none at %0t",
                        eaf_addr_o, $time);
            end else begin
               ei = issueQ.pop_front();
               checkOutput("issue_op", 32'(eaf_insert_o), 32'(ei.op));
               checkOutput("issue_addr", eaf_addr_o, ei.addr);
            end
            if (eaf_test_o) begin
               pendHit = (hitQ.size() != 0) ? hitQ.pop_front() : 1'b0;
               testSeq++;
            end
         end
         if (fill_valid_o && !fillSeen) begin
            if (fillQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL fill_unexp: got fill addr 0x%08h expected none at %0t",
                        fill_addr_o, $time);
            end else begin
               ef = fillQ.pop_front();
               checkOutput("fill_addr", fill_addr_o, ef.addr);
               checkOutput("fill_mru", 32'(fill_mru_o), 32'(ef.mru));
            end
            fillSeen = 1'b1;
         end
         if (!fill_valid_o || fill_ready_i) begin
            fillSeen = 1'b0;
         end
      end
   end

   // Filter model: exists is valid only in the cycle after the test pulse.
   always @(posedge clk) begin
      #1;
      if (testSeq != drvSeq) begin
         eaf_exists_i = pendHit;
         drvSeq = testSeq;
      end else begin
         eaf_exists_i = 1'b0;
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [31:0] addr;
      logic        hit;
      logic [31:0] expLine;
      logic        expMru;
   } vec_t;

   initial begin
      vec_t vecs[5];
      logic macc, eacc;
      logic [4:0] hitPat;

      vecs[0] = '{32'h1234_5678, 1'b1, 32'h1234_5640, 1'b1};
      vecs[1] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFC0, 1'b0};
      vecs[2] = '{32'h0000_003F, 1'b1, 32'h0000_0000, 1'b1};
      vecs[3] = '{32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEC0, 1'b0};
      vecs[4] = '{32'h0000_0040, 1'b1, 32'h0000_0040, 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_addr", eaf_addr_o, 32'd0);
      checkOutput("rst_test", 32'(eaf_test_o), 32'd0);
      checkOutput("rst_insert", 32'(eaf_insert_o), 32'd0);
      checkOutput("rst_fvalid", 32'(fill_valid_o), 32'd0);
      checkOutput("rst_faddr", fill_addr_o, 32'd0);
      checkOutput("rst_fmru", 32'(fill_mru_o), 32'd0);
      checkOutput("rst_mready", 32'(miss_ready_o), 32'd1);
      checkOutput("rst_eready", 32'(evict_ready_o), 32'd1);
      #2;
      rst_n = 1'b1;
      stepCycle();

      // Single miss with filter hit, result held while fill logic stalls
      fill_ready_i = 1'b0;
      applyStimulus(1'b1, 32'h0000_1234, 1'b1, 1'b0, 32'd0, macc, eacc);
      checkOutput("t1_acc", 32'(macc), 32'd1);
      stepCycle();
      checkOutput("t1_pulse", 32'(eaf_test_o), 32'd1);
      checkOutput("t1_paddr", eaf_addr_o, 32'h0000_1200);
      stepCycle();
      checkOutput("t1_pulse_end", 32'(eaf_test_o), 32'd0);
      checkOutput("t1_hold_addr", eaf_addr_o, 32'h0000_1200);
      stepCycle();
      for (int i = 0; i < 3; i++) begin
         checkOutput("t1_fvalid", 32'(fill_valid_o), 32'd1);
         checkOutput("t1_faddr", fill_addr_o, 32'h0000_1200);
         checkOutput("t1_fmru", 32'(fill_mru_o), 32'd1);
         stepCycle();
      end
      fill_ready_i = 1'b1;
      stepCycle();
      checkOutput("t1_consumed", 32'(fill_valid_o), 32'd0);
      checkOutput("t1_addr_kept", eaf_addr_o, 32'h0000_1200);
      fill_ready_i = 1'b0;
      drain(20);

      // Address table: offset masking and MRU/LRU selection
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, vecs[i].addr, vecs[i].hit, 1'b0, 32'd0, macc, eacc);
         waitFill(10);
         checkOutput("vec_line", fill_addr_o, vecs[i].expLine);
         checkOutput("vec_mru", 32'(fill_mru_o), 32'(vecs[i].expMru));
         fill_ready_i = 1'b1;
         stepCycle();
         fill_ready_i = 1'b0;
         drain(20);
      end

      // Eviction then miss of the same line: insert first, LRU result
      fill_ready_i = 1'b1;
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h8000_0040, macc, eacc);
      checkOutput("t2_eacc", 32'(eacc), 32'd1);
      applyStimulus(1'b1, 32'h8000_0040, 1'b0, 1'b0, 32'd0, macc, eacc);
      checkOutput("t2_macc", 32'(macc), 32'd1);
      drain(30);

      // Same-cycle miss and eviction into an empty queue
      applyStimulus(1'b1, 32'h0000_2011, 1'b1, 1'b1, 32'h0000_3022, macc, eacc);
      checkOutput("t3_macc", 32'(macc), 32'd1);
      checkOutput("t3_eacc", 32'(eacc), 32'd1);
      drain(30);

      // Back-pressure: park a test in RESP, fill the queue, check readiness at the boundary
      fill_ready_i = 1'b0;
      applyStimulus(1'b1, 32'h0000_4000, 1'b1, 1'b0, 32'd0, macc, eacc);
      waitFill(10);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_5000 + 32'(i) * 32'h40, macc, eacc);
         checkOutput("t4_eacc", 32'(eacc), 32'd1);
      end
      applyStimulus(1'b1, 32'h0000_6000, 1'b0, 1'b1, 32'h0000_7000, macc, eacc);
      checkOutput("t4_last_macc", 32'(macc), 32'd1);
      checkOutput("t4_last_eacc", 32'(eacc), 32'd0);
      checkOutput("t4_full_mready", 32'(miss_ready_o), 32'd0);
      checkOutput("t4_full_eready", 32'(evict_ready_o), 32'd0);
      applyStimulus(1'b1, 32'h0000_8000, 1'b0, 1'b1, 32'h0000_9000, macc, eacc);
      checkOutput("t4_blocked_m", 32'(macc), 32'd0);
      checkOutput("t4_blocked_e", 32'(eacc), 32'd0);
      fill_ready_i = 1'b1;
      drain(60);

      // Asynchronous reset during WAIT of a test with an eviction still queued
      applyStimulus(1'b1, 32'h0000_A000, 1'b1, 1'b1, 32'h0000_B000, macc, eacc);
      stepCycle();
      checkOutput("t5_issue", 32'(eaf_test_o), 32'd1);
      stepCycle();
      checkOutput("t5_in_wait", eaf_addr_o, 32'h0000_A000);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_test", 32'(eaf_test_o), 32'd0);
      checkOutput("t5_rst_insert", 32'(eaf_insert_o), 32'd0);
      checkOutput("t5_rst_addr", eaf_addr_o, 32'd0);
      checkOutput("t5_rst_fvalid", 32'(fill_valid_o), 32'd0);
      checkOutput("t5_rst_faddr", fill_addr_o, 32'd0);
      checkOutput("t5_rst_fmru", 32'(fill_mru_o), 32'd0);
      issueQ.delete();
      fillQ.delete();
      hitQ.delete();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         stepCycle();
         checkOutput("t5_post_test", 32'(eaf_test_o), 32'd0);
         checkOutput("t5_post_insert", 32'(eaf_insert_o), 32'd0);
         checkOutput("t5_post_fvalid", 32'(fill_valid_o), 32'd0);
         checkOutput("t5_post_eready", 32'(evict_ready_o), 32'd1);
      end
      applyStimulus(1'b1, 32'h0000_C0FF, 1'b0, 1'b0, 32'd0, macc, eacc);
      drain(30);

`ifdef EAF_REQ_STATS_EN
      // Statistics: 5 tests (2 hits) and 3 inserts after a fresh reset
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #4;
      rst_n = 1'b1;
      stepCycle();
      hitPat = 5'b00101;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h0001_0000 + 32'(i) * 32'h100, hitPat[i], 1'b0, 32'd0, macc, eacc);
         drain(30);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0002_0000 + 32'(i) * 32'h100, macc, eacc);
         drain(30);
      end
      checkOutput("stat_tests", 32'(stat_tests_o), 32'd5);
      checkOutput("stat_hits", 32'(stat_hits_o), 32'd2);
      checkOutput("stat_inserts", 32'(stat_inserts_o), 32'd3);
      checkOutput("stat_full", 32'(stat_full_o), 32'd0);
`else
      hitPat = 5'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
